// File: rtl/nonogram_pkg.sv
// rtl/nonogram_pkg.sv - board sizing, derived widths and streamer state encoding
package nonogram_pkg;

   localparam int SIZE      = 3;
   localparam int NUM_LINES = 2 * SIZE;
   localparam int MAX_OPTS  = 64;
   localparam int ADDR_W    = 10;
   localparam int LINE_W    = $clog2(NUM_LINES);
   localparam int CNT_W     = $clog2(MAX_OPTS + 1);
   localparam int QCNT_W    = $clog2(NUM_LINES + 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_POP,
      ST_SEND_IDX,
      ST_FETCH,
      ST_CAPTURE,
      ST_SEND_OPT,
      ST_WAIT_FB,
      ST_DONE
   } streamer_state_t;

endpackage

// File: rtl/line_queue.sv
// rtl/line_queue.sv - circular FIFO of line indices with wrapping rd/wr pointers
// Depth need not be a power of two; pointers wrap explicitly at DEPTH-1.
module line_queue #(
   parameter int DEPTH = 6,
   parameter int W     = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wrap_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= wrap_inc(rd_ptr);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);

endmodule

// File: rtl/nonogram_option_streamer.sv
// rtl/nonogram_option_streamer.sv - pops unresolved lines and streams index + options to the solver
// Define STREAMER_STATS_EN to add saturating words_sent / lines_requeued counters.
module nonogram_option_streamer
   import nonogram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [LINE_W-1:0] cfg_line,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic              start,
   input  logic              solver_ready,
   input  logic              fb_valid,
   input  logic              put_back_to_FIFO,
   input  logic              solved,
   output logic [ADDR_W-1:0] opt_addr,
   input  logic [SIZE-1:0]   opt_rdata,
   output logic [SIZE-1:0]   option,
   output logic              valid_op,
   output logic              started,
   output logic              busy,
   output logic              done,
   output logic              stuck
`ifdef STREAMER_STATS_EN
   ,
   output logic [15:0]       words_sent,
   output logic [15:0]       lines_requeued
`endif
);

   streamer_state_t state_q, state_d;

   logic [ADDR_W-1:0] cfg_base_q  [NUM_LINES];
   logic [CNT_W-1:0]  cfg_count_q [NUM_LINES];
   logic [LINE_W-1:0] scan_q;
   logic [LINE_W-1:0] line_q;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  k_q;
   logic [SIZE-1:0]   opt_q;
   logic              first_q;
   logic              stuck_q;
   logic              solved_seen_q;

   logic              any_lines;
   logic              idle_like;
   logic              launch;
   logic              stop;
   logic              xfer;
   logic              last_opt;
   logic              q_push;
   logic              q_pop;
   logic              q_empty;
   logic [LINE_W-1:0] q_push_data;
   logic [LINE_W-1:0] q_pop_data;
   logic [QCNT_W-1:0] q_count;

   always_comb begin
      any_lines = 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (cfg_count_q[i] != '0) any_lines = 1'b1;
      end
   end

   assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign launch    = idle_like && start;
   // solved may pulse while a word is pending; remember it until that word is taken
   assign stop      = solved || solved_seen_q;
   assign xfer      = valid_op && solver_ready;
   assign last_opt  = ((k_q + CNT_W'(1)) == count_q);

   assign q_push = (q_count != QCNT_W'(NUM_LINES)) &&
                   (((state_q == ST_LOAD) && (cfg_count_q[scan_q] != '0)) ||
                    ((state_q == ST_WAIT_FB) && fb_valid && put_back_to_FIFO && !stop));
   assign q_push_data = (state_q == ST_LOAD) ? scan_q : line_q;
   assign q_pop       = (state_q == ST_POP) && !stop && !q_empty;

   line_queue #(
      .DEPTH (NUM_LINES),
      .W     (LINE_W)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (launch),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .pop_data  (q_pop_data),
      .empty     (q_empty),
      .count     (q_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < NUM_LINES; i++) begin
            cfg_base_q[i]  <= '0;
            cfg_count_q[i] <= '0;
         end
         scan_q        <= '0;
         line_q        <= '0;
         base_q        <= '0;
         count_q       <= '0;
         k_q           <= '0;
         opt_q         <= '0;
         first_q       <= 1'b0;
         stuck_q       <= 1'b0;
         solved_seen_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cfg_we && idle_like && (cfg_line < LINE_W'(NUM_LINES))) begin
            cfg_base_q[cfg_line]  <= cfg_base;
            cfg_count_q[cfg_line] <= cfg_count;
         end
         if (launch) begin
            scan_q        <= '0;
            first_q       <= 1'b1;
            stuck_q       <= !any_lines;
            solved_seen_q <= 1'b0;
         end else if (!idle_like && solved) begin
            solved_seen_q <= 1'b1;
         end
         if (state_q == ST_LOAD) scan_q <= scan_q + LINE_W'(1);
         if (q_pop) begin
            line_q  <= q_pop_data;
            base_q  <= cfg_base_q[q_pop_data];
            count_q <= cfg_count_q[q_pop_data];
         end
         if ((state_q == ST_POP) && !stop && q_empty) stuck_q <= 1'b1;
         if ((state_q == ST_SEND_IDX) && xfer) begin
            first_q <= 1'b0;
            k_q     <= '0;
         end
         if ((state_q == ST_SEND_OPT) && xfer) k_q <= k_q + CNT_W'(1);
         if (state_q == ST_CAPTURE) opt_q <= opt_rdata;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = any_lines ? ST_LOAD : ST_DONE;
         ST_LOAD: begin
            if (stop) state_d = ST_DONE;
            else if (scan_q == LINE_W'(NUM_LINES - 1)) state_d = ST_POP;
         end
         ST_POP:      state_d = (stop || q_empty) ? ST_DONE : ST_SEND_IDX;
         ST_SEND_IDX: if (xfer) state_d = stop ? ST_DONE : ST_FETCH;
         ST_FETCH:    state_d = stop ? ST_DONE : ST_CAPTURE;
         ST_CAPTURE:  state_d = stop ? ST_DONE : ST_SEND_OPT;
         // the next option address is presented while waiting, so FETCH is skipped
         ST_SEND_OPT: begin
            if (xfer) state_d = stop ? ST_DONE : (last_opt ? ST_WAIT_FB : ST_CAPTURE);
         end
         ST_WAIT_FB: begin
            if (stop) state_d = ST_DONE;
            else if (fb_valid) state_d = ST_POP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      valid_op = 1'b0;
      started  = 1'b0;
      option   = '0;
      opt_addr = '0;
      busy     = !idle_like;
      done     = (state_q == ST_DONE);
      stuck    = stuck_q && (state_q == ST_DONE);
      unique case (state_q)
         ST_SEND_IDX: begin
            valid_op = 1'b1;
            started  = first_q;
            option   = SIZE'(line_q);
         end
         ST_FETCH: opt_addr = base_q + ADDR_W'(k_q);
         ST_SEND_OPT: begin
            valid_op = 1'b1;
            option   = opt_q;
            opt_addr = base_q + ADDR_W'(k_q) + ADDR_W'(1);
         end
         default: ;
      endcase
   end

`ifdef STREAMER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || launch) begin
         words_sent     <= '0;
         lines_requeued <= '0;
      end else begin
         if (xfer && (words_sent != 16'hFFFF)) words_sent <= words_sent + 16'd1;
         if ((state_q == ST_WAIT_FB) && q_push && (lines_requeued != 16'hFFFF)) begin
            lines_requeued <= lines_requeued + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_nonogram_option_streamer.sv
// tb/tb_nonogram_option_streamer.sv - randomized option-stream check against a queue-level model
`timescale 1ns/1ps
module tb_nonogram_option_streamer;
   import nonogram_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, cfg_we, start, solver_ready, fb_valid, put_back_to_FIFO, solved;
   logic [LINE_W-1:0] cfg_line;
   logic [ADDR_W-1:0] cfg_base;
   logic [CNT_W-1:0]  cfg_count;
   logic [ADDR_W-1:0] opt_addr;
   logic [SIZE-1:0]   opt_rdata, option;
   logic              valid_op, started, busy, done, stuck;
`ifdef STREAMER_STATS_EN
   logic [15:0]       words_sent, lines_requeued;
`endif

   nonogram_option_streamer dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_we           (cfg_we),
      .cfg_line         (cfg_line),
      .cfg_base         (cfg_base),
      .cfg_count        (cfg_count),
      .start            (start),
      .solver_ready     (solver_ready),
      .fb_valid         (fb_valid),
      .put_back_to_FIFO (put_back_to_FIFO),
      .solved           (solved),
      .opt_addr         (opt_addr),
      .opt_rdata        (opt_rdata),
      .option           (option),
      .valid_op         (valid_op),
      .started          (started),
      .busy             (busy),
      .done             (done),
      .stuck            (stuck)
`ifdef STREAMER_STATS_EN
      ,
      .words_sent       (words_sent),
      .lines_requeued   (lines_requeued)
`endif
   );

   logic [SIZE-1:0] mem [1 << ADDR_W];
   always @(posedge clk) opt_rdata <= mem[opt_addr];

   int cnt  [NUM_LINES];
   int base [NUM_LINES];
   int reps [NUM_LINES];
   int exp_q[$];
   int got_q[$];
   bit exp_stuck;
   int n_requeue;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line-level model: queue of line numbers, each visit emits index then its options
   task automatic build_model(input int solve_at);
      int q[$];
      int vis[NUM_LINES];
      int n;
      int l;
      exp_q.delete();
      exp_stuck = 1'b1;
      n = 0;
      for (int i = 0; i < NUM_LINES; i++) begin
         vis[i] = 0;
         if (cnt[i] > 0) q.push_back(i);
      end
      while (q.size() > 0) begin
         l = q.pop_front();
         exp_q.push_back(l);
         for (int k = 0; k < cnt[l]; k++) exp_q.push_back(int'(mem[(base[l] + k) & ((1 << ADDR_W) - 1)]));
         vis[l]++;
         if (n == solve_at) begin
            exp_stuck = 1'b0;
            break;
         end
         n++;
         if (vis[l] <= reps[l]) q.push_back(l);
      end
   endtask

   task automatic run(input int solve_at, input int ready_pct, input int stall_at, input bit poke);
      int vis[NUM_LINES];
      int cur, remaining, fb_wait, cyc, started_n, started_bad, stall_left, lines_seen, quiet_bad;
      bit fin, held;
      logic [SIZE-1:0] held_opt;
      build_model(solve_at);
      got_q.delete();
      n_requeue = 0;
      foreach (vis[i]) vis[i] = 0;
      cur = 0; remaining = 0; fb_wait = -1; cyc = 0; started_n = 0; started_bad = 0;
      stall_left = 3; lines_seen = 0; quiet_bad = 0; fin = 1'b0; held = 1'b0; held_opt = '0;
      for (int l = 0; l < NUM_LINES; l++) begin
         @(negedge clk);
         cfg_we = 1'b1; cfg_line = LINE_W'(l); cfg_base = ADDR_W'(base[l]); cfg_count = CNT_W'(cnt[l]);
      end
      @(negedge clk); cfg_we = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!fin && cyc < 5000) begin
         fb_valid = 1'b0; put_back_to_FIFO = 1'b0; cfg_we = 1'b0;
         if (fb_wait == 0) begin
            if (lines_seen - 1 == solve_at) solved = 1'b1;
            else begin
               fb_valid = 1'b1;
               put_back_to_FIFO = (vis[cur] <= reps[cur]);
               if (put_back_to_FIFO) n_requeue++;
            end
            fb_wait = -1;
         end else if (fb_wait > 0) fb_wait--;
         if (poke && cyc == 4) begin
            cfg_we = 1'b1; cfg_line = '0; cfg_base = '0; cfg_count = CNT_W'(5);
         end
         #1;
         if (held) begin
            check("hold_valid", valid_op, 1);
            check("hold_option", option, held_opt);
         end
         if (valid_op && stall_left > 0 && got_q.size() == stall_at) begin
            solver_ready = 1'b0;
            stall_left--;
         end else solver_ready = ($urandom_range(0, 99) < ready_pct);
         if (started && got_q.size() != 0) started_bad++;
         if (valid_op && solver_ready) begin
            if (started) started_n++;
            got_q.push_back(int'(option));
            if (remaining == 0) begin
               cur = int'(option);
               lines_seen++;
               if (cur < NUM_LINES) begin
                  vis[cur]++;
                  remaining = cnt[cur];
               end
            end else begin
               remaining--;
               if (remaining == 0) fb_wait = $urandom_range(0, 2);
            end
         end
         held = valid_op && !solver_ready;
         held_opt = option;
         if (done) fin = 1'b1;
         cyc++;
         @(negedge clk);
      end
      cfg_we = 1'b0; fb_valid = 1'b0; solver_ready = 1'b1;
      check("run_finished", fin, 1);
      repeat (5) begin
         #1;
         if (valid_op) quiet_bad++;
         @(negedge clk);
      end
      solved = 1'b0;
      check("quiet_after_done", quiet_bad, 0);
      check("done", done, 1);
      check("stuck", stuck, exp_stuck);
      check("busy", busy, 0);
      check("stream_len", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check($sformatf("word%0d", i), got_q[i], exp_q[i]);
      check("started_count", started_n, (exp_q.size() > 0) ? 1 : 0);
      check("started_only_first", started_bad, 0);
`ifdef STREAMER_STATS_EN
      check("words_sent", words_sent, exp_q.size());
      check("lines_requeued", lines_requeued, n_requeue);
`endif
      if (!fin) begin
         rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
   endtask

   task automatic setup_fixed();
      int c[NUM_LINES] = '{2, 3, 1, 1, 2, 3};
      int b[NUM_LINES] = '{0, 2, 5, 6, 7, 9};
      int d[12] = '{6, 3, 4, 2, 1, 5, 5, 6, 3, 4, 2, 1};
      for (int i = 0; i < NUM_LINES; i++) begin
         cnt[i] = c[i]; base[i] = b[i]; reps[i] = 0;
      end
      for (int i = 0; i < 12; i++) mem[i] = SIZE'(d[i]);
   endtask

   task automatic reset_and_empty_start();
      bit seen, ok, got_done;
      int vbad;
      seen = 1'b0; ok = 1'b0; got_done = 1'b0; vbad = 0;
      solver_ready = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         #1;
         if (valid_op && seen) ok = 1'b1;
         else begin
            solver_ready = valid_op;
            if (valid_op) seen = 1'b1;
         end
         @(negedge clk);
      end
      check("reached_send_opt", ok, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_option", option, 0);
      check("rst_valid_op", valid_op, 0);
      check("rst_started", started, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stuck", stuck, 0);
      check("rst_opt_addr", opt_addr, 0);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         if (done) got_done = 1'b1;
         if (valid_op) vbad++;
         @(negedge clk);
      end
      check("empty_done_fast", got_done, 1);
      check("empty_stuck", stuck, 1);
      repeat (6) begin
         #1;
         if (valid_op) vbad++;
         @(negedge clk);
      end
      check("empty_no_valid", vbad, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s1[18] = '{0, 6, 3, 1, 4, 2, 1, 2, 5, 3, 5, 4, 6, 3, 5, 4, 2, 1};
      rst = 1'b1; cfg_we = 1'b0; cfg_line = '0; cfg_base = '0; cfg_count = '0; start = 1'b0;
      solver_ready = 1'b0; fb_valid = 1'b0; put_back_to_FIFO = 1'b0; solved = 1'b0;
      foreach (mem[i]) mem[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_option", option, 0);
      check("reset_valid_op", valid_op, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_opt_addr", opt_addr, 0);

      setup_fixed();
      run(-1, 100, -1, 1'b0);
      for (int i = 0; i < 18; i++) check($sformatf("fixed_word%0d", i), (i < got_q.size()) ? got_q[i] : -1, s1[i]);

      setup_fixed(); reps[0] = 1;
      run(-1, 100, -1, 1'b0);

      setup_fixed();
      run(2, 100, -1, 1'b0);

      setup_fixed();
      run(-1, 100, 5, 1'b0);

      reset_and_empty_start();

      for (int it = 0; it < 8; it++) begin
         foreach (mem[i]) mem[i] = SIZE'($urandom);
         for (int l = 0; l < NUM_LINES; l++) begin
            cnt[l]  = $urandom_range(0, 4);
            base[l] = $urandom_range(0, (1 << ADDR_W) - 1);
            reps[l] = $urandom_range(0, 2);
         end
         base[NUM_LINES - 1] = (1 << ADDR_W) - 2;
         run(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1, 65, -1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
